vga_pixel_unpacker: RTL
=======================

// Module: vga_pixel_unpacker
// PURPOSE
//  Parametrised VGA pixel engine between the DDR read FIFO (first-word-fall-through) and the DAC pins.
//  Contains its own timing generator and unpacks DATA_W-bit FIFO words into PIX_W-bit pixel slots.
//  Detects FIFO underflow, blanks and re-aligns at the next frame start, and supports a colour-bar test pattern.
// PARAMETERS
//  DATA_W    128  FIFO word width; must be an integer multiple of PIX_W
//  PIX_W     32   bits per pixel slot: [7:0]=R, [15:8]=G, [23:16]=B, rest ignored; PPW=DATA_W/PIX_W, power of 2
//  H_ACTIVE  640  active pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (front porch, sync, back porch, pixels)
//  V_ACTIVE  480  active lines per frame; V_FP 10, V_SYNC 2, V_BP 33 (lines)
//  SYNC_POL  0    hs/vs asserted level (0 = active-low)
// PORTS
//  vga_clk        in   1       pixel clock
//  vga_reset_n    in   1       asynchronous, active-low reset
//  test_pat       in   1       1 = show colour bars instead of FIFO data
//  fifo_empty     in   1       DDR read FIFO empty
//  fifo_rd_data   in   DATA_W  FIFO head word (valid when !fifo_empty)
//  fifo_rd        out  1       pop strobe, combinational
//  vga_r/g/b      out  8 each  pixel colour, registered
//  vga_hs, vga_vs out  1 each  syncs, registered, polarity SYNC_POL
//  vga_blank_n    out  1       1 during active video, registered
//  vga_sync_n     out  1       constant 1 after reset
//  underflow      out  1       sticky underflow flag
//  clr_underflow  in   1       clears underflow (set wins if same cycle)
// BEHAVIOUR
//  Reset (async): state IDLE; h=v=slot=0; rgb=0; hs,vs=~SYNC_POL; blank_n=0; sync_n=1; underflow=0.
//  Counters: h in 0..H_TOT-1, H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP; v increments when h wraps and itself wraps at V_TOT.
//  Origin: h=0, v=0 is the first active pixel. active = h<H_ACTIVE && v<V_ACTIVE.
//  hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs uses the same rule on v with V_* parameters.
//  Outputs are registered from counter state, so there is 1 cycle latency from counter to pins.
//  States:
//   IDLE: counters held at 0, outputs at reset values. Goes to RUN when !fifo_empty.
//   RUN: counters free-run. On an active pixel the slot advances as slot=(slot+1) mod PPW.
//     fifo_rd = active && slot==PPW-1 && !fifo_empty. Pixel colour comes from bits [slot*PIX_W +: 24].
//     An active pixel with fifo_empty: pixel is black, underflow<=1, go to RESYNC. Slot is not advanced and there is no pop.
//   RESYNC: counters free-run, all active pixels black, no pops. On the cycle h,v wrap to 0,0: slot<=0,
//     then go to RUN if !fifo_empty, otherwise go to IDLE (counters held at 0).
//  Slot is forced to 0 at every frame wrap; H_ACTIVE*V_ACTIVE must be a multiple of PPW.
//  test_pat=1 replaces colour only. Popping, slot advance and underflow detection are unchanged.
//  Colour bars: 8 bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black (levels 0/255).
//  Inactive pixels: rgb=0, blank_n=0, in every state.
//  Reset mid-frame: returns to reset values immediately. fifo_rd is 0 during reset.
// TESTING (bench params: H 8/2/2/2, V 4/1/1/1, DATA_W=128, PIX_W=32, H_TOT=14, V_TOT=7)
//  T1 reset, fifo_empty=1 for 50 clk -> fifo_rd=0, hs=vs=1, blank_n=0, rgb=0, state stays IDLE.
//  T2 FIFO preloaded with 8 words, word n slot k = {8'h0, n, k, 8'hA0} -> first active pixel r=A0,g=00,b=00 1 clk after RUN.
//     fifo_rd pulses at h=3 and h=7 of every active line; 8 pops per frame.
//  T3 pattern check -> hs low exactly at h=10,11; vs low exactly on line 5; blank_n high 8 clk per active line.
//  T4 empty FIFO at frame 0, line 2, h=4 -> that pixel and the rest of the frame are black, underflow=1, no pops.
//     At the next frame, the first pixel is slot 0 of the head word.
//  T5 test_pat=1 -> one bar per pixel: h=0 rgb FF/FF/FF, h=1 FF/FF/00, h=7 00/00/00. fifo_rd pattern identical to T2.
//  T6 reset asserted mid-line -> all outputs return to reset values asynchronously. Restart aligns at slot 0; underflow is cleared.

Source files
------------

// File: rtl/vga_pixel_unpacker.sv
// VGA pixel engine: timing generator plus FIFO word unpacker.
// Underflow blanks the rest of the frame and re-aligns at frame start.
module vga_pixel_unpacker #(
   parameter int DATA_W   = 128,
   parameter int PIX_W    = 32,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic              vga_clk,
   input  logic              vga_reset_n,
   input  logic              test_pat,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic              vga_sync_n,
   output logic              underflow,
   input  logic              clr_underflow
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PPW   = DATA_W / PIX_W;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int SW    = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_BARW = HW'(BAR_W);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
   localparam logic [SW-1:0] S_LAST = SW'(PPW - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESYNC} state_t;

   state_t state, state_nxt;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic [SW-1:0] slot;
   logic          active, h_wrap, f_wrap, in_hs, in_vs;
   logic [2:0]    bar;
   logic [PPW-1:0][PIX_W-1:0] words;
   logic [23:0]   wpix;
   logic          words_unused;

   logic          slot_adv, uf_set, blank_nxt, hs_nxt, vs_nxt;
   logic [7:0]    r_nxt, g_nxt, b_nxt;

   assign active = (h < H_ACT) && (v < V_ACT);
   assign h_wrap = (h == H_LAST);
   assign f_wrap = h_wrap && (v == V_LAST);
   assign in_hs  = (h >= H_SS) && (h < H_SE);
   assign in_vs  = (v >= V_SS) && (v < V_SE);
   assign bar    = 3'(h / H_BARW);

   assign words        = fifo_rd_data;
   assign wpix         = words[slot][23:0];
   assign words_unused = ^words;
   assign vga_sync_n   = 1'b1;

   always_ff @(posedge vga_clk or negedge vga_reset_n) begin
      if (!vga_reset_n) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!fifo_empty) state_nxt = RUN;
         RUN:     if (active && fifo_empty) state_nxt = RESYNC;
         RESYNC:  if (f_wrap) state_nxt = fifo_empty ? IDLE : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd   = 1'b0;
      slot_adv  = 1'b0;
      uf_set    = 1'b0;
      r_nxt     = 8'h00;
      g_nxt     = 8'h00;
      b_nxt     = 8'h00;
      blank_nxt = 1'b0;
      hs_nxt    = ~SYNC_POL;
      vs_nxt    = ~SYNC_POL;
      if (state != IDLE) begin
         blank_nxt = active;
         hs_nxt    = in_hs ? SYNC_POL : ~SYNC_POL;
         vs_nxt    = in_vs ? SYNC_POL : ~SYNC_POL;
      end
      if (state == RUN && active) begin
         if (fifo_empty) begin
            uf_set = 1'b1;
         end else begin
            slot_adv = 1'b1;
            fifo_rd  = (slot == S_LAST);
            if (test_pat) begin
               // bar order white..black maps to these index bits
               r_nxt = {8{~bar[1]}};
               g_nxt = {8{~bar[2]}};
               b_nxt = {8{~bar[0]}};
            end else begin
               r_nxt = wpix[7:0];
               g_nxt = wpix[15:8];
               b_nxt = wpix[23:16];
            end
         end
      end
   end

   always_ff @(posedge vga_clk or negedge vga_reset_n) begin
      if (!vga_reset_n) begin
         h           <= '0;
         v           <= '0;
         slot        <= '0;
         vga_r       <= 8'h00;
         vga_g       <= 8'h00;
         vga_b       <= 8'h00;
         vga_hs      <= ~SYNC_POL;
         vga_vs      <= ~SYNC_POL;
         vga_blank_n <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         vga_r       <= r_nxt;
         vga_g       <= g_nxt;
         vga_b       <= b_nxt;
         vga_hs      <= hs_nxt;
         vga_vs      <= vs_nxt;
         vga_blank_n <= blank_nxt;
         if (uf_set)             underflow <= 1'b1;
         else if (clr_underflow) underflow <= 1'b0;
         if (state == IDLE) begin
            h <= '0;
            v <= '0;
         end else begin
            h <= h_wrap ? '0 : h + HW'(1);
            if (h_wrap) v <= (v == V_LAST) ? '0 : v + VW'(1);
         end
         if (state == IDLE || f_wrap) slot <= '0;
         else if (slot_adv)           slot <= (slot == S_LAST) ? '0 : slot + SW'(1);
      end
   end

endmodule
